branch_resolve_unit: RTL

Pipelined, parametrised branch resolution unit for the pipelined RV32I core. It evaluates all six conditional-branch conditions from funct3, computes the branch target, compares the outcome against the front-end prediction, and issues a redirect on a mispredict. A valid/ready elastic pipeline of configurable depth carries the results, with flush support and saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves RV32I conditional branches. It evaluates the funct3 condition,
// computes pc+imm, checks the outcome against the front-end prediction and
// produces a redirect PC. Results travel through a valid/ready elastic
// pipeline that is 1 or 2 stages deep (LATENCY). Saturating counters track
// resolved branches and mispredicts.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      request handshake
//   funct3, rs1_data,        branch type and operands
//   rs2_data, pc, imm
//   pred_taken, pred_target  front-end prediction
//   flush                    drop every in-flight request
//   out_valid / out_ready    result handshake
//   taken, target,           resolved direction, pc+imm, redirect request,
//   mispredict, redirect_pc  and the PC to fetch next
//   illegal                  funct3 is 010 or 011
//   br_cnt, mp_cnt           saturating branch / mispredict counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    // ---------------- compare (always on the request inputs) ----------------
    logic w_eq, w_lt, w_ltu, w_cond, w_illegal;

    assign w_eq      = (rs1_data == rs2_data);
    assign w_lt      = ($signed(rs1_data) < $signed(rs2_data));
    assign w_ltu     = (rs1_data < rs2_data);
    assign w_illegal = (funct3[2:1] == 2'b01);

    // Illegal encodings fall to the default and resolve not-taken.
    always_comb begin
        case (funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = !w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = !w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    // ---------------- output stage state ----------------
    logic             r_valid, r_taken, r_mp, r_illegal;
    logic [XLEN-1:0]  r_target, r_redir;
    logic [CNT_W-1:0] r_br_cnt, r_mp_cnt;

    // Output stage can take new data when empty or draining this cycle.
    logic w_out_adv;
    assign w_out_adv = !r_valid || out_ready;

    // Source feeding the output stage: the raw request (LATENCY=1) or the
    // registered compare stage (LATENCY=2).
    logic            w_b_valid, w_b_taken, w_b_illegal, w_b_pt;
    logic [XLEN-1:0] w_b_pc, w_b_imm, w_b_ptgt;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign in_ready    = w_out_adv;
            assign w_b_valid   = in_valid;
            assign w_b_taken   = w_cond;
            assign w_b_illegal = w_illegal;
            assign w_b_pt      = pred_taken;
            assign w_b_pc      = pc;
            assign w_b_imm     = imm;
            assign w_b_ptgt    = pred_target;
        end else begin : g_lat2
            logic            r_s0_valid, r_s0_taken, r_s0_illegal, r_s0_pt;
            logic [XLEN-1:0] r_s0_pc, r_s0_imm, r_s0_ptgt;

            assign in_ready = !r_s0_valid || w_out_adv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s0_valid   <= 1'b0;
                    r_s0_taken   <= 1'b0;
                    r_s0_illegal <= 1'b0;
                    r_s0_pt      <= 1'b0;
                    r_s0_pc      <= '0;
                    r_s0_imm     <= '0;
                    r_s0_ptgt    <= '0;
                end else begin
                    if (flush)
                        r_s0_valid <= 1'b0;
                    else if (in_ready)
                        r_s0_valid <= in_valid;
                    if (in_valid && in_ready) begin
                        r_s0_taken   <= w_cond;
                        r_s0_illegal <= w_illegal;
                        r_s0_pt      <= pred_taken;
                        r_s0_pc      <= pc;
                        r_s0_imm     <= imm;
                        r_s0_ptgt    <= pred_target;
                    end
                end
            end

            assign w_b_valid   = r_s0_valid;
            assign w_b_taken   = r_s0_taken;
            assign w_b_illegal = r_s0_illegal;
            assign w_b_pt      = r_s0_pt;
            assign w_b_pc      = r_s0_pc;
            assign w_b_imm     = r_s0_imm;
            assign w_b_ptgt    = r_s0_ptgt;
        end
    endgenerate

    // ---------------- target / mispredict ----------------
    logic [XLEN-1:0] w_target, w_seq, w_redir;
    logic            w_mp;

    assign w_target = w_b_pc + w_b_imm;      // modulo 2^XLEN
    assign w_seq    = w_b_pc + XLEN'(4);
    assign w_redir  = w_b_taken ? w_target : w_seq;
    assign w_mp     = (w_b_taken != w_b_pt) || (w_b_taken && (w_target != w_b_ptgt));

    // Counted handshake: a result leaving under flush is delivered, not counted.
    logic w_hs;
    assign w_hs = r_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_mp      <= 1'b0;
            r_illegal <= 1'b0;
            r_target  <= '0;
            r_redir   <= '0;
            r_br_cnt  <= '0;
            r_mp_cnt  <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_out_adv)
                r_valid <= w_b_valid;
            // Data only moves on a load, so a stalled result stays put.
            if (w_out_adv && w_b_valid) begin
                r_taken   <= w_b_taken;
                r_mp      <= w_mp;
                r_illegal <= w_b_illegal;
                r_target  <= w_target;
                r_redir   <= w_redir;
            end
            if (w_hs) begin
                if (r_br_cnt != {CNT_W{1'b1}})
                    r_br_cnt <= r_br_cnt + 1'b1;
                if (r_mp && (r_mp_cnt != {CNT_W{1'b1}}))
                    r_mp_cnt <= r_mp_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_valid;
    assign taken       = r_taken;
    assign target      = r_target;
    assign mispredict  = r_mp;
    assign redirect_pc = r_redir;
    assign illegal     = r_illegal;
    assign br_cnt      = r_br_cnt;
    assign mp_cnt      = r_mp_cnt;

endmodule
